// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS control sequencer.
package mc_pkg;

  // Sequencer states; every instruction starts in FETCH
  typedef enum logic [2:0] {
    FETCH,
    DCD,
    EXE,
    MEM,
    WB
  } state_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  // Next-PC source select
  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  // Instruction class: decides the state path through the sequencer.
  // CL_ALU covers both R-type arithmetic and the immediate forms (EXE -> WB).
  typedef enum logic [2:0] {
    CL_ILL,
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_BEQ,
    CL_J,
    CL_JR,
    CL_JAL
  } iclass_t;

  // Per-instruction datapath settings; the sequencer decides when they apply
  typedef struct packed {
    logic       alusrc;
    logic [2:0] aluop;
    logic       ext_sel;
    logic       regdst;
    logic       memtoreg;
    logic       lb_flag;
    logic       of_control;
    logic       jal_sel;
  } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: op/funct -> class plus control bundle.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output ctrl_t      ctrl
);

  // Anything not listed decodes as illegal with an all-zero bundle
  always_comb begin
    iclass = CL_ILL;
    ctrl   = '0;
    case (op)
      OP_R: begin
        case (funct)
          FN_ADDU: begin iclass = CL_ALU; ctrl.regdst = 1'b1; ctrl.aluop = ALU_ADD; end
          FN_SUBU: begin iclass = CL_ALU; ctrl.regdst = 1'b1; ctrl.aluop = ALU_SUB; end
          FN_SLT:  begin iclass = CL_ALU; ctrl.regdst = 1'b1; ctrl.aluop = ALU_SLT; end
          FN_JR:   iclass = CL_JR;
          default: ;
        endcase
      end
      OP_ORI: begin
        iclass = CL_ALU; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_OR;
      end
      OP_LUI: begin
        iclass = CL_ALU; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_LUI;
      end
      OP_ADDI: begin
        iclass = CL_ALU; ctrl.alusrc = 1'b1; ctrl.ext_sel = 1'b1;
        ctrl.aluop = ALU_ADD; ctrl.of_control = 1'b1;
      end
      OP_LW: begin
        iclass = CL_LOAD; ctrl.alusrc = 1'b1; ctrl.ext_sel = 1'b1;
        ctrl.aluop = ALU_ADD; ctrl.memtoreg = 1'b1;
      end
      OP_LB: begin
        iclass = CL_LOAD; ctrl.alusrc = 1'b1; ctrl.ext_sel = 1'b1;
        ctrl.aluop = ALU_ADD; ctrl.memtoreg = 1'b1; ctrl.lb_flag = 1'b1;
      end
      OP_SW: begin
        iclass = CL_STORE; ctrl.alusrc = 1'b1; ctrl.ext_sel = 1'b1;
        ctrl.aluop = ALU_ADD;
      end
      OP_BEQ: begin
        iclass = CL_BEQ; ctrl.aluop = ALU_SUB;
      end
      OP_J:   iclass = CL_J;
      OP_JAL: begin
        iclass = CL_JAL; ctrl.jal_sel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle sequencer for the single-bus MIPS datapath. Walks each
// instruction through FETCH/DCD/EXE/MEM/WB and drives the datapath strobes.
// Outputs are decoded from the current state; reset gates them immediately.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic [1:0] npc_sel,
  output logic       alusrc,
  output logic [2:0] aluop,
  output logic       ext_sel,
  output logic       regdst,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       memwrite,
  output logic       lb_flag,
  output logic       of_control,
  output logic       jal_sel,
  output logic       instr_done,
  output logic       ill_op,
  output logic       mem_err
);

  localparam int               CNT_W    = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  iclass_t          iclass;
  ctrl_t            ctrl;
  logic             mem_timeout;

  mc_decode u_decode (
    .op     (op),
    .funct  (funct),
    .iclass (iclass),
    .ctrl   (ctrl)
  );

  // Last permitted MEM cycle passed without the memory answering
  assign mem_timeout = (wait_cnt == CNT_LAST) && !mem_rdy;

  // State register and MEM wait counter; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
    end else begin
      case (state)
        FETCH: state <= DCD;
        DCD: begin
          case (iclass)
            CL_J, CL_JR, CL_ILL: state <= FETCH;
            CL_JAL:              state <= WB;
            default:             state <= EXE;
          endcase
        end
        EXE: begin
          case (iclass)
            CL_LOAD, CL_STORE: state <= MEM;
            CL_BEQ:            state <= FETCH;
            default:           state <= WB;
          endcase
        end
        MEM: begin
          if (mem_rdy) begin
            wait_cnt <= '0;
            state    <= (iclass == CL_STORE) ? FETCH : WB;
          end else if (mem_timeout) begin
            wait_cnt <= '0;
            state    <= FETCH;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        WB:      state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  // State-qualified strobe generation; ALU settings stay up from EXE through WB
  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    npc_sel    = NPC_PC4;
    alusrc     = 1'b0;
    aluop      = ALU_ADD;
    ext_sel    = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    memwrite   = 1'b0;
    lb_flag    = 1'b0;
    of_control = 1'b0;
    jal_sel    = 1'b0;
    instr_done = 1'b0;
    ill_op     = 1'b0;
    mem_err    = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
        end
        DCD: begin
          case (iclass)
            CL_J:   begin pc_wr = 1'b1; npc_sel = NPC_J;  instr_done = 1'b1; end
            CL_JR:  begin pc_wr = 1'b1; npc_sel = NPC_JR; instr_done = 1'b1; end
            CL_JAL: begin pc_wr = 1'b1; npc_sel = NPC_J; end
            CL_ILL: begin ill_op = 1'b1; instr_done = 1'b1; end
            default: ;
          endcase
        end
        EXE: begin
          alusrc  = ctrl.alusrc;
          aluop   = ctrl.aluop;
          ext_sel = ctrl.ext_sel;
          // Branch target was formed from the PC+4 already committed in FETCH
          if (iclass == CL_BEQ) begin
            npc_sel    = NPC_BR;
            pc_wr      = zero;
            instr_done = 1'b1;
          end
        end
        MEM: begin
          alusrc     = ctrl.alusrc;
          aluop      = ctrl.aluop;
          ext_sel    = ctrl.ext_sel;
          memwrite   = (iclass == CL_STORE);
          lb_flag    = ctrl.lb_flag;
          mem_err    = mem_timeout;
          instr_done = mem_timeout || (mem_rdy && (iclass == CL_STORE));
        end
        WB: begin
          alusrc     = ctrl.alusrc;
          aluop      = ctrl.aluop;
          ext_sel    = ctrl.ext_sel;
          regwrite   = 1'b1;
          regdst     = ctrl.regdst;
          memtoreg   = ctrl.memtoreg;
          of_control = ctrl.of_control;
          jal_sel    = ctrl.jal_sel;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
